mem_access_sched: RTL

- Sequential round-robin scheduler that shares one memory/interconnect port among num_req requesters.
- Fronts the shared data path: grants one owner at a time and holds the grant for a bounded burst.
- Forwards the owner's words through a one-entry registered output stage with valid/ready backpressure.
- Fairness is round-robin rotation, replacing conflict-flop tie-breaking; per-requester serviced acks are exported.

---
 rtl/mem_access_sched.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_access_sched.sv
// Round-robin scheduler sharing one memory port among num_req requesters.
// Grants one owner per bounded burst and forwards its words through a registered valid/ready stage.
module mem_access_sched #(
  parameter int num_req    = 8,
  parameter int data_width = 132,
  parameter int max_burst  = 4,
  localparam int ow        = $clog2(num_req)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [num_req-1:0]            req,
  input  logic [num_req-1:0]            last,
  input  logic [num_req*data_width-1:0] d_IN,
  output logic [num_req-1:0]            serv,
  output logic [data_width-1:0]         d_OUT,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ow-1:0]                 owner,
  output logic                          active
);

  localparam int bw = $clog2(max_burst + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nx;
  logic [ow-1:0]         rr_ptr, rr_nx, owner_nx, pick, owner_inc;
  logic [bw-1:0]         beat_cnt, beat_nx;
  logic [data_width-1:0] d_nx, word;
  logic                  valid_nx, can_load, accept, last_beat, found;

  function automatic logic [ow-1:0] wrap_idx(input logic [ow-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= num_req) s = s - num_req;
    return ow'(s);
  endfunction

  // Rotating priority search: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < num_req; k++) begin
      if (!found && req[wrap_idx(rr_ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign word      = d_IN[owner*data_width +: data_width];
  assign can_load  = !out_valid || out_ready;
  // Reset gates accept so no serv pulse escapes in the reset cycle.
  assign accept    = rst_n && (state == GRANT) && req[owner] && can_load;
  assign last_beat = (beat_cnt + bw'(1)) == bw'(max_burst);
  assign owner_inc = (owner == ow'(num_req - 1)) ? '0 : owner + ow'(1);
  assign active    = (state == GRANT);

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    beat_nx  = beat_cnt;
    valid_nx = out_valid;
    d_nx     = d_OUT;
    serv     = '0;

    if (accept) begin
      serv[owner] = 1'b1;
      d_nx        = word;
      valid_nx    = 1'b1;
      beat_nx     = beat_cnt + bw'(1);
    end else if (out_ready) begin
      valid_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          owner_nx = pick;
          beat_nx  = '0;
        end
      end
      GRANT: begin
        if (!req[owner] || (accept && (last[owner] || last_beat))) begin
          state_nx = IDLE;
          rr_nx    = owner_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      d_OUT     <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      owner     <= owner_nx;
      beat_cnt  <= beat_nx;
      out_valid <= valid_nx;
      d_OUT     <= d_nx;
    end
  end

endmodule
